// File: rtl/switch_press_counter.sv
// Purpose: synchronise and debounce one bouncing switch and count its presses as 4-digit BCD.
// Latency: a level held from edge E is accepted at edge E+DEBOUNCE_CYCLES+1; the count updates on that same edge.
// Backpressure: none; the block runs every cycle, and clear takes priority over a press on the same edge.
//
// Ports:
//   clock      - system clock, all state on the rising edge
//   reset      - asynchronous, active-high reset
//   switch_raw - raw, asynchronous, bouncing switch level
//   clear      - synchronous clear of the press count and the overflow flag
//   clean      - debounced switch level
//   pressed    - one-cycle pulse per accepted press, coincident with clean rising
//   value      - press count, 4 BCD digits ([3:0] units .. [15:12] thousands)
//   dots       - {overflow, 1'b0, 1'b0, clean}
module switch_press_counter #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        switch_raw,
  input  logic        clear,
  output logic        clean,
  output logic        pressed,
  output logic [15:0] value,
  output logic [3:0]  dots
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  // The counter starts at 1 on the first differing sample, so reaching
  // DEBOUNCE_CYCLES-1 while the next sample still differs means
  // DEBOUNCE_CYCLES consecutive samples.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept_rise;
  logic             accept_fall;
  logic             ovf_q;
  logic [15:0]      value_inc;
  logic             value_carry;

  // Two-flop synchroniser; s2 is the only copy of the switch the FSM sees.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= switch_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          // Bounce: drop the partial run, nothing is counted.
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = STABLE_HIGH;
          cnt_d       = '0;
          accept_rise = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = STABLE_LOW;
          cnt_d       = '0;
          accept_fall = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Ripple BCD increment; carry out of the thousands digit means 9999 -> 0000.
  // Any digit at 9 or above rolls to 0, so an illegal A-F digit cannot persist.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    value_inc = value;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      digit = value[4*i +: 4];
      if (carry) begin
        if (digit >= 4'd9) begin
          value_inc[4*i +: 4] = 4'd0;
        end else begin
          value_inc[4*i +: 4] = digit + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    value_carry = carry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clean   <= 1'b0;
      pressed <= 1'b0;
    end else begin
      pressed <= accept_rise;
      if (accept_rise) begin
        clean <= 1'b1;
      end else if (accept_fall) begin
        clean <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      value <= '0;
      ovf_q <= 1'b0;
    end else if (accept_rise) begin
      value <= value_inc;
      if (value_carry) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign dots = {ovf_q, 2'b00, clean};

endmodule

// File: tb/tb_switch_press_counter.sv
module tb_switch_press_counter;

  localparam int D = 4;

  logic        clock;
  logic        reset;
  logic        switch_raw;
  logic        clear;
  logic        clean;
  logic        pressed;
  logic [15:0] value;
  logic [3:0]  dots;

  int total = 0;
  int bad   = 0;

  switch_press_counter #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .switch_raw (switch_raw),
    .clear      (clear),
    .clean      (clean),
    .pressed    (pressed),
    .value      (value),
    .dots       (dots)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the switch reaches the debouncer two edges late; a level
  // is accepted once D consecutive delayed samples disagree with the current
  // debounced level. Presses are counted as a plain integer 0..9999.
  logic m_h1, m_h2, m_clean, m_pressed, m_ovf, m_samp, m_rose;
  int   m_run, m_count;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_h1 = 0; m_h2 = 0; m_clean = 0; m_pressed = 0; m_ovf = 0;
      m_run = 0; m_count = 0;
    end else begin
      m_samp = m_h2;
      m_h2   = m_h1;
      m_h1   = switch_raw;
      m_rose = 0;
      if (m_samp != m_clean) begin
        m_run++;
        if (m_run == D) begin
          m_clean = m_samp;
          m_run   = 0;
          m_rose  = m_samp;
        end
      end else begin
        m_run = 0;
      end
      m_pressed = m_rose;
      if (clear) begin
        m_count = 0;
        m_ovf   = 0;
      end else if (m_rose) begin
        if (m_count == 9999) begin
          m_count = 0;
          m_ovf   = 1;
        end else begin
          m_count++;
        end
      end
    end
  end

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  // Stimulus only: D samples high then D samples low, starting at a negedge.
  task automatic do_press();
    switch_raw = 1'b1;
    repeat (D) @(negedge clock);
    switch_raw = 1'b0;
    repeat (D) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; switch_raw = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clock);
    total += 4;
    if (clean !== 1'b0) begin bad++; $display("FAIL reset_clean: got %b want 0", clean); end
    if (pressed !== 1'b0) begin bad++; $display("FAIL reset_pressed: got %b want 0", pressed); end
    if (value !== 16'h0000) begin bad++; $display("FAIL reset_value: got %h want 0000", value); end
    if (dots !== 4'b0000) begin bad++; $display("FAIL reset_dots: got %b want 0000", dots); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b011011;
    for (int i = 0; i < 14; i++) begin
      switch_raw = (i < 6) ? pat[5 - i] : 1'b0;
      @(negedge clock);
      total += 2;
      if (clean !== 1'b0) begin bad++; $display("FAIL bounce_clean cyc%0d: got %b want 0", i, clean); end
      if (pressed !== 1'b0) begin bad++; $display("FAIL bounce_pressed cyc%0d: got %b want 0", i, pressed); end
    end
    total++;
    if (value !== 16'h0000) begin bad++; $display("FAIL bounce_value: got %h want 0000", value); end
  endtask

  task automatic test_clean_press();
    switch_raw = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clock);
      total += 2;
      if (pressed !== (k == 5)) begin bad++; $display("FAIL press_pulse E+%0d: got %b want %b", k, pressed, (k == 5)); end
      if (clean !== (k >= 5)) begin bad++; $display("FAIL press_clean E+%0d: got %b want %b", k, clean, (k >= 5)); end
      if (k == 5) begin
        total += 2;
        if (value !== 16'h0001) begin bad++; $display("FAIL press_value: got %h want 0001", value); end
        if (dots !== 4'b0001) begin bad++; $display("FAIL press_dots: got %b want 0001", dots); end
      end
    end
    switch_raw = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clock);
      total += 2;
      if (pressed !== 1'b0) begin bad++; $display("FAIL release_pulse E+%0d: got %b want 0", k, pressed); end
      if (clean !== (k < 5)) begin bad++; $display("FAIL release_clean E+%0d: got %b want %b", k, clean, (k < 5)); end
    end
    total += 2;
    if (value !== 16'h0001) begin bad++; $display("FAIL release_value: got %h want 0001", value); end
    if (dots !== 4'b0000) begin bad++; $display("FAIL release_dots: got %b want 0000", dots); end
  endtask

  task automatic test_bcd_carry();
    repeat (9) do_press();
    total += 2;
    if (value !== 16'h0010) begin bad++; $display("FAIL carry_10: got %h want 0010", value); end
    if (value !== to_bcd(m_count)) begin bad++; $display("FAIL carry_10_model: got %h want %h", value, to_bcd(m_count)); end
    repeat (989) do_press();
    total++;
    if (value !== 16'h0999) begin bad++; $display("FAIL carry_999: got %h want 0999", value); end
    do_press();
    total += 2;
    if (value !== 16'h1000) begin bad++; $display("FAIL carry_1000: got %h want 1000", value); end
    if (dots[3] !== 1'b0) begin bad++; $display("FAIL carry_ovf: got %b want 0", dots[3]); end
  endtask

  task automatic test_wrap();
    repeat (8999) do_press();
    total += 2;
    if (value !== 16'h9999) begin bad++; $display("FAIL wrap_9999: got %h want 9999", value); end
    if (dots[3] !== 1'b0) begin bad++; $display("FAIL wrap_pre_ovf: got %b want 0", dots[3]); end
    do_press();
    total += 2;
    if (value !== 16'h0000) begin bad++; $display("FAIL wrap_value: got %h want 0000", value); end
    if (dots[3] !== 1'b1) begin bad++; $display("FAIL wrap_ovf: got %b want 1", dots[3]); end
    repeat (3) @(negedge clock);
    total++;
    if (dots[3] !== 1'b1) begin bad++; $display("FAIL wrap_ovf_sticky: got %b want 1", dots[3]); end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    total += 2;
    if (value !== 16'h0000) begin bad++; $display("FAIL clear_value: got %h want 0000", value); end
    if (dots[3] !== 1'b0) begin bad++; $display("FAIL clear_ovf: got %b want 0", dots[3]); end
  endtask

  task automatic test_clear_press();
    do_press();
    repeat (4) @(negedge clock);
    total++;
    if (value !== 16'h0001) begin bad++; $display("FAIL clrpress_pre: got %h want 0001", value); end
    switch_raw = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clock);
      if (k == 4) clear = 1'b1;
      if (k == 5) begin
        clear = 1'b0;
        total += 3;
        if (pressed !== 1'b1) begin bad++; $display("FAIL clrpress_pulse: got %b want 1", pressed); end
        if (clean !== 1'b1) begin bad++; $display("FAIL clrpress_clean: got %b want 1", clean); end
        if (value !== 16'h0000) begin bad++; $display("FAIL clrpress_value: got %h want 0000", value); end
      end
    end
    @(negedge clock);
    total++;
    if (value !== 16'h0000) begin bad++; $display("FAIL clrpress_after: got %h want 0000", value); end
    switch_raw = 1'b0;
    repeat (D + 4) @(negedge clock);
  endtask

  task automatic test_async_reset();
    do_press();
    repeat (4) @(negedge clock);
    switch_raw = 1'b1;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total += 4;
    if (clean !== 1'b0) begin bad++; $display("FAIL areset_clean: got %b want 0", clean); end
    if (pressed !== 1'b0) begin bad++; $display("FAIL areset_pressed: got %b want 0", pressed); end
    if (value !== 16'h0000) begin bad++; $display("FAIL areset_value: got %h want 0000", value); end
    if (dots !== 4'b0000) begin bad++; $display("FAIL areset_dots: got %b want 0000", dots); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      total += 2;
      if (clean !== (k >= D + 2)) begin bad++; $display("FAIL areset_rise edge%0d: got %b want %b", k, clean, (k >= D + 2)); end
      if (pressed !== (k == D + 2)) begin bad++; $display("FAIL areset_pulse edge%0d: got %b want %b", k, pressed, (k == D + 2)); end
    end
    total++;
    if (value !== 16'h0001) begin bad++; $display("FAIL areset_count: got %h want 0001", value); end
  endtask

  task automatic test_random();
    int left;
    left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      total += 4;
      if (clean !== m_clean) begin bad++; if (bad < 40) $display("FAIL rand_clean cyc%0d: got %b want %b", i, clean, m_clean); end
      if (pressed !== m_pressed) begin bad++; if (bad < 40) $display("FAIL rand_pressed cyc%0d: got %b want %b", i, pressed, m_pressed); end
      if (value !== to_bcd(m_count)) begin bad++; if (bad < 40) $display("FAIL rand_value cyc%0d: got %h want %h", i, value, to_bcd(m_count)); end
      if (dots !== {m_ovf, 2'b00, m_clean}) begin bad++; if (bad < 40) $display("FAIL rand_dots cyc%0d: got %b want %b", i, dots, {m_ovf, 2'b00, m_clean}); end
      if (left == 0) begin
        switch_raw = ~switch_raw;
        left = int'($urandom_range(1, 7));
      end
      left--;
      clear = ($urandom_range(0, 49) == 0);
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_bcd_carry();
    test_wrap();
    test_clear_press();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
